// File: rtl/decode_queue_pkg.sv
// Shared types for the decode queue: decoder info, immediate selectors,
// queue entry layout and the immediate extraction helpers.
package decode_queue_pkg;

    typedef enum logic [2:0] {
        DATA_IMM_NONE,
        DATA_IMM_S12,
        DATA_IMM_S20,
        DATA_IMM_U12,
        DATA_IMM_U5
    } data_imm_e;

    typedef enum logic [2:0] {
        ADDR_IMM_NONE,
        ADDR_IMM_S12,
        ADDR_IMM_S14,
        ADDR_IMM_S16,
        ADDR_IMM_S26
    } addr_imm_e;

    typedef struct packed {
        logic      legal;
        logic      is_branch;
        logic      is_load;
        logic      is_store;
        logic [4:0] rd;
        logic [4:0] rj;
        logic [4:0] rk;
        data_imm_e data_imm_type;
        addr_imm_e addr_imm_type;
    } decoder_info_t;

    typedef struct packed {
        logic [31:0]   pc;
        logic [31:0]   inst;
        decoder_info_t info;
        logic [31:0]   data_imm;
        logic [31:0]   addr_imm;
    } dq_entry_t;

    localparam int ENTRY_W = $bits(dq_entry_t);

    // Major opcodes, left-aligned at inst[31]
    localparam logic [9:0]  OP_ADDI_W = 10'b0000001010;
    localparam logic [9:0]  OP_ANDI   = 10'b0000001101;
    localparam logic [9:0]  OP_ORI    = 10'b0000001110;
    localparam logic [9:0]  OP_XORI   = 10'b0000001111;
    localparam logic [9:0]  OP_LD_W   = 10'b0010100010;
    localparam logic [9:0]  OP_ST_W   = 10'b0010100110;
    localparam logic [6:0]  OP_LU12I  = 7'b0001010;
    localparam logic [16:0] OP_SLLI_W = 17'b00000000010000001;
    localparam logic [16:0] OP_SRLI_W = 17'b00000000010001001;
    localparam logic [16:0] OP_SRAI_W = 17'b00000000010010001;
    localparam logic [7:0]  OP_LL_W   = 8'b00100000;
    localparam logic [7:0]  OP_SC_W   = 8'b00100001;
    localparam logic [5:0]  OP_JIRL   = 6'b010011;
    localparam logic [5:0]  OP_B      = 6'b010100;
    localparam logic [5:0]  OP_BL     = 6'b010101;
    localparam logic [5:0]  OP_BEQ    = 6'b010110;
    localparam logic [5:0]  OP_BGEU   = 6'b011011;

    function automatic logic [31:0] gen_data_imm(input logic [31:0] inst, input data_imm_e sel);
        case (sel)
            DATA_IMM_S12: return {{20{inst[21]}}, inst[21:10]};
            DATA_IMM_S20: return {{12{inst[24]}}, inst[24:5]};
            DATA_IMM_U12: return {20'b0, inst[21:10]};
            DATA_IMM_U5:  return {27'b0, inst[14:10]};
            default:      return 32'b0;
        endcase
    endfunction

    // Branch offsets are word offsets, hence the trailing 2'b00
    function automatic logic [31:0] gen_addr_imm(input logic [31:0] inst, input addr_imm_e sel);
        case (sel)
            ADDR_IMM_S12: return {{20{inst[21]}}, inst[21:10]};
            ADDR_IMM_S14: return {{16{inst[23]}}, inst[23:10], 2'b00};
            ADDR_IMM_S16: return {{14{inst[25]}}, inst[25:10], 2'b00};
            ADDR_IMM_S26: return {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
            default:      return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/basic_decoder.sv
// Single-slot instruction classifier: register fields, instruction class and
// which immediate formats apply.
module basic_decoder
    import decode_queue_pkg::*;
(
    input  logic [31:0]   inst_i,
    output decoder_info_t info_o
);

    always_comb begin
        info_o               = '0;
        info_o.rd            = inst_i[4:0];
        info_o.rj            = inst_i[9:5];
        info_o.rk            = inst_i[14:10];
        info_o.data_imm_type = DATA_IMM_NONE;
        info_o.addr_imm_type = ADDR_IMM_NONE;

        if (inst_i[31:22] == OP_ADDI_W) begin
            info_o.legal         = 1'b1;
            info_o.data_imm_type = DATA_IMM_S12;
        end else if (inst_i[31:22] == OP_ANDI || inst_i[31:22] == OP_ORI || inst_i[31:22] == OP_XORI) begin
            info_o.legal         = 1'b1;
            info_o.data_imm_type = DATA_IMM_U12;
        end else if (inst_i[31:25] == OP_LU12I) begin
            info_o.legal         = 1'b1;
            info_o.data_imm_type = DATA_IMM_S20;
        end else if (inst_i[31:15] == OP_SLLI_W || inst_i[31:15] == OP_SRLI_W || inst_i[31:15] == OP_SRAI_W) begin
            info_o.legal         = 1'b1;
            info_o.data_imm_type = DATA_IMM_U5;
        end else if (inst_i[31:22] == OP_LD_W || inst_i[31:22] == OP_ST_W) begin
            info_o.legal         = 1'b1;
            info_o.is_load       = (inst_i[31:22] == OP_LD_W);
            info_o.is_store      = (inst_i[31:22] == OP_ST_W);
            info_o.addr_imm_type = ADDR_IMM_S12;
        end else if (inst_i[31:24] == OP_LL_W || inst_i[31:24] == OP_SC_W) begin
            info_o.legal         = 1'b1;
            info_o.is_load       = (inst_i[31:24] == OP_LL_W);
            info_o.is_store      = (inst_i[31:24] == OP_SC_W);
            info_o.addr_imm_type = ADDR_IMM_S14;
        end else if (inst_i[31:26] == OP_B || inst_i[31:26] == OP_BL) begin
            info_o.legal         = 1'b1;
            info_o.is_branch     = 1'b1;
            info_o.addr_imm_type = ADDR_IMM_S26;
        end else if (inst_i[31:26] == OP_JIRL || (inst_i[31:26] >= OP_BEQ && inst_i[31:26] <= OP_BGEU)) begin
            info_o.legal         = 1'b1;
            info_o.is_branch     = 1'b1;
            info_o.addr_imm_type = ADDR_IMM_S16;
        end
    end

endmodule

// File: rtl/decode_compactor.sv
// Packs the masked-valid slots of a fetch packet into the low end of a dense
// array, preserving program order, and reports how many survived.
module decode_compactor
    import decode_queue_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int PN_W    = $clog2(FETCH_W + 1)
) (
    input  logic [FETCH_W-1:0]      mask_i,
    input  dq_entry_t [FETCH_W-1:0] slots_i,
    output dq_entry_t [FETCH_W-1:0] dense_o,
    output logic [PN_W-1:0]         push_n_o
);

    always_comb begin
        int cnt;
        cnt     = 0;
        dense_o = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            for (int j = 0; j < FETCH_W; j++) begin
                if (mask_i[i] && cnt == j) begin
                    dense_o[j] = slots_i[i];
                end
            end
            cnt = cnt + int'(mask_i[i]);
        end
        push_n_o = PN_W'(cnt);
    end

endmodule

// File: rtl/decode_queue.sv
// Decode queue between fetch and rename: decodes, compacts and buffers fetch
// packets in a circular queue. Optional perf counters via DECODE_QUEUE_PERF_EN.
module decode_queue
    import decode_queue_pkg::*;
#(
    parameter int FETCH_W = 2,
    parameter int ISSUE_W = 2,
    parameter int DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [FETCH_W-1:0]         in_mask_i,
    input  logic [FETCH_W*32-1:0]      in_pc_i,
    input  logic [FETCH_W*32-1:0]      in_inst_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [ISSUE_W-1:0]         out_mask_o,
    output logic [ISSUE_W*ENTRY_W-1:0] out_entry_o,
`ifdef DECODE_QUEUE_PERF_EN
    output logic [31:0]                perf_full_stall_o,
    output logic [31:0]                perf_empty_cycles_o,
`endif
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int PN_W  = $clog2(FETCH_W + 1);

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    dq_entry_t        mem_q [DEPTH];
    dq_entry_t        mem_d [DEPTH];

    decoder_info_t             slot_info [FETCH_W];
    dq_entry_t [FETCH_W-1:0]   slot_entry;
    dq_entry_t [FETCH_W-1:0]   dense;
    logic [PN_W-1:0]           push_n_raw;
    logic [CNT_W-1:0]          push_n, pop_n, free_slots;
    logic                      push, pop;

    for (genvar g = 0; g < FETCH_W; g++) begin : g_slot
        basic_decoder u_dec (
            .inst_i (in_inst_i[g*32 +: 32]),
            .info_o (slot_info[g])
        );
        assign slot_entry[g] = {in_pc_i[g*32 +: 32], in_inst_i[g*32 +: 32], slot_info[g],
                                gen_data_imm(in_inst_i[g*32 +: 32], slot_info[g].data_imm_type),
                                gen_addr_imm(in_inst_i[g*32 +: 32], slot_info[g].addr_imm_type)};
    end

    decode_compactor #(.FETCH_W(FETCH_W), .PN_W(PN_W)) u_compactor (
        .mask_i   (in_mask_i),
        .slots_i  (slot_entry),
        .dense_o  (dense),
        .push_n_o (push_n_raw)
    );

    // Readiness depends only on the registered count, so it never waits on rename
    assign free_slots  = CNT_W'(DEPTH) - count_q;
    assign in_ready_o  = free_slots >= CNT_W'(FETCH_W);
    assign push        = in_valid_i && in_ready_o && !flush_i;
    assign push_n      = CNT_W'(push_n_raw);
    assign out_valid_o = count_q != '0;
    assign pop_n       = (count_q > CNT_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : count_q;
    assign pop         = out_valid_o && out_ready_i && !flush_i;
    assign count_o     = count_q;

    always_comb begin
        out_mask_o  = '0;
        out_entry_o = '0;
        for (int k = 0; k < ISSUE_W; k++) begin
            out_mask_o[k]                      = count_q > CNT_W'(k);
            out_entry_o[k*ENTRY_W +: ENTRY_W] = mem_q[head_q + PTR_W'(k)];
        end
    end

    // NOTE: every always_comb output is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        mem_d   = mem_q;
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                for (int i = 0; i < FETCH_W; i++) begin
                    if (CNT_W'(i) < push_n) begin
                        mem_d[tail_q + PTR_W'(i)] = dense[i];
                    end
                end
                tail_d = tail_q + PTR_W'(push_n);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(pop_n);
            end
            count_d = count_q + (push ? push_n : '0) - (pop ? pop_n : '0);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // NOTE: entry storage is deliberately not reset; count gates every read, so stale data is never presented.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

`ifdef DECODE_QUEUE_PERF_EN
    logic [31:0] perf_full_stall_q, perf_full_stall_d;
    logic [31:0] perf_empty_cycles_q, perf_empty_cycles_d;

    // Saturating counters; flush leaves them alone
    always_comb begin
        perf_full_stall_d   = perf_full_stall_q;
        perf_empty_cycles_d = perf_empty_cycles_q;
        if (in_valid_i && !in_ready_o && perf_full_stall_q != '1) begin
            perf_full_stall_d = perf_full_stall_q + 32'd1;
        end
        if (count_q == '0 && perf_empty_cycles_q != '1) begin
            perf_empty_cycles_d = perf_empty_cycles_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_full_stall_q   <= '0;
            perf_empty_cycles_q <= '0;
        end else begin
            perf_full_stall_q   <= perf_full_stall_d;
            perf_empty_cycles_q <= perf_empty_cycles_d;
        end
    end

    assign perf_full_stall_o   = perf_full_stall_q;
    assign perf_empty_cycles_o = perf_empty_cycles_q;
`endif

endmodule

// File: tb/tb_decode_queue.sv
// Self-checking bench for decode_queue: decode vector table, hand-written
// corner sequences and a random soak, all checked against a scoreboard queue.
module tb_decode_queue;
    import decode_queue_pkg::*;

    localparam int FETCH_W = 2;
    localparam int ISSUE_W = 2;
    localparam int DEPTH   = 8;

    logic                       clk = 1'b0;
    logic                       rst_n, flush_i, in_valid_i, out_ready_i;
    logic                       in_ready_o, out_valid_o;
    logic [FETCH_W-1:0]         in_mask_i;
    logic [ISSUE_W-1:0]         out_mask_o;
    logic [FETCH_W*32-1:0]      in_pc_i, in_inst_i;
    logic [ISSUE_W*ENTRY_W-1:0] out_entry_o;
    logic [$clog2(DEPTH):0]     count_o;

    always #5 clk = ~clk;

    decode_queue #(.FETCH_W(FETCH_W), .ISSUE_W(ISSUE_W), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_mask_i   (in_mask_i),
        .in_pc_i     (in_pc_i),
        .in_inst_i   (in_inst_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_mask_o  (out_mask_o),
        .out_entry_o (out_entry_o),
        .count_o     (count_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] data_imm;
        logic [31:0] addr_imm;
    } exp_t;

    typedef struct {
        string       name;
        logic [31:0] inst;
        logic [31:0] data_imm;
        logic [31:0] addr_imm;
    } vec_t;

    exp_t        sb[$];
    exp_t        slot_exp[FETCH_W];
    vec_t        vecs[15];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] pc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_slot(input int s, input logic [31:0] p, input logic [31:0] inst,
                            input logic [31:0] dimm, input logic [31:0] aimm);
        in_pc_i[s*32 +: 32]   = p;
        in_inst_i[s*32 +: 32] = inst;
        slot_exp[s].pc        = p;
        slot_exp[s].inst      = inst;
        slot_exp[s].data_imm  = dimm;
        slot_exp[s].addr_imm  = aimm;
    endtask

    // Filler traffic: addi.w whose immediate is taken from the PC
    task automatic set_addi(input int s, input logic [31:0] p);
        logic [11:0] imm;
        imm = p[13:2];
        set_slot(s, p, {10'b0000001010, imm, 5'd3, 5'd4}, {{20{imm[11]}}, imm}, 32'h0);
    endtask

    task automatic set_pair();
        set_addi(0, pc);
        set_addi(1, pc + 32'd4);
        pc = pc + 32'd8;
    endtask

    // Compare presented state with the scoreboard, update it for this edge, then advance
    task automatic tick();
        int        n_exp, n_pop;
        bit        exp_ready;
        dq_entry_t e;
        n_exp     = sb.size();
        exp_ready = (DEPTH - n_exp) >= FETCH_W;
        n_pop     = (n_exp < ISSUE_W) ? n_exp : ISSUE_W;
        check("in_ready", 32'(in_ready_o), 32'(exp_ready));
        check("out_valid", 32'(out_valid_o), 32'(n_exp > 0));
        check("out_mask", 32'(out_mask_o), 32'((1 << n_pop) - 1));
        for (int k = 0; k < n_pop; k++) begin
            e = out_entry_o[k*ENTRY_W +: ENTRY_W];
            check($sformatf("entry%0d_pc", k), e.pc, sb[k].pc);
            check($sformatf("entry%0d_inst", k), e.inst, sb[k].inst);
            check($sformatf("entry%0d_data_imm", k), e.data_imm, sb[k].data_imm);
            check($sformatf("entry%0d_addr_imm", k), e.addr_imm, sb[k].addr_imm);
        end
        if (!rst_n || flush_i) begin
            sb.delete();
        end else begin
            if (out_ready_i) begin
                for (int k = 0; k < n_pop; k++) void'(sb.pop_front());
            end
            if (in_valid_i && exp_ready) begin
                for (int s = 0; s < FETCH_W; s++) begin
                    if (in_mask_i[s]) sb.push_back(slot_exp[s]);
                end
            end
        end
        @(posedge clk);
        #1;
        check("count", 32'(count_o), 32'(sb.size()));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n       = 1'b0;
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        in_mask_i   = '0;
        in_pc_i     = '0;
        in_inst_i   = '0;
        pc          = 32'h1c00_1000;

        vecs[0]  = '{"addi_neg",  {10'b0000001010, 12'hFFF, 5'd1, 5'd2}, 32'hFFFF_FFFF, 32'h0};
        vecs[1]  = '{"addi_pos",  {10'b0000001010, 12'h7FF, 5'd1, 5'd2}, 32'h0000_07FF, 32'h0};
        vecs[2]  = '{"lu12i",     {7'b0001010, 20'h80000, 5'd3},         32'hFFF8_0000, 32'h0};
        vecs[3]  = '{"ori",       {10'b0000001110, 12'hFFF, 5'd1, 5'd2}, 32'h0000_0FFF, 32'h0};
        vecs[4]  = '{"slli",      {17'b00000000010000001, 5'd31, 5'd1, 5'd2}, 32'h0000_001F, 32'h0};
        vecs[5]  = '{"ld_w",      {10'b0010100010, 12'h800, 5'd1, 5'd2}, 32'h0, 32'hFFFF_F800};
        vecs[6]  = '{"st_w",      {10'b0010100110, 12'h004, 5'd1, 5'd2}, 32'h0, 32'h0000_0004};
        vecs[7]  = '{"ll_w",      {8'b00100000, 14'h2000, 5'd1, 5'd2},   32'h0, 32'hFFFF_8000};
        vecs[8]  = '{"sc_w",      {8'b00100001, 14'h0001, 5'd1, 5'd2},   32'h0, 32'h0000_0004};
        vecs[9]  = '{"beq_neg",   {6'b010110, 16'h8000, 5'd1, 5'd2},     32'h0, 32'hFFFE_0000};
        vecs[10] = '{"jirl_pos",  {6'b010011, 16'h7FFF, 5'd1, 5'd2},     32'h0, 32'h0001_FFFC};
        vecs[11] = '{"bl_neg",    {6'b010101, 16'hFFFF, 10'h3FF},        32'h0, 32'hFFFF_FFFC};
        vecs[12] = '{"bl_one",    {6'b010101, 16'h0001, 10'h000},        32'h0, 32'h0000_0004};
        vecs[13] = '{"b_hi",      {6'b010100, 16'h0000, 10'h001},        32'h0, 32'h0004_0000};
        vecs[14] = '{"illegal",   32'h0000_0000,                         32'h0, 32'h0};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_count", 32'(count_o), 32'd0);
        check("rst_out_valid", 32'(out_valid_o), 32'd0);
        check("rst_out_mask", 32'(out_mask_o), 32'd0);
        check("rst_in_ready", 32'(in_ready_o), 32'd1);

        // Two-slot packet, visible next cycle in PC order
        set_addi(0, 32'h1c00_0000);
        set_addi(1, 32'h1c00_0004);
        in_mask_i  = 2'b11;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("pkt_count", 32'(count_o), 32'd2);
        check("pkt_mask", 32'(out_mask_o), 32'd3);
        tick();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // Only slot 1 valid: compacted to entry 0
        set_addi(0, 32'h1c00_0100);
        set_addi(1, 32'h1c00_0104);
        in_mask_i  = 2'b10;
        in_valid_i = 1'b1;
        tick();
        in_valid_i = 1'b0;
        check("compact_count", 32'(count_o), 32'd1);
        check("compact_mask", 32'(out_mask_o), 32'd1);
        check("compact_pc", out_entry_o[ENTRY_W-1 -: 32], 32'h1c00_0104);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // Decode table, alternating which slot carries the vector
        foreach (vecs[i]) begin
            set_pair();
            set_slot(i % 2, 32'h1c00_2000 + 32'(i * 4), vecs[i].inst, vecs[i].data_imm, vecs[i].addr_imm);
            in_mask_i  = (i % 2 == 1) ? 2'b10 : 2'b01;
            in_valid_i = 1'b1;
            tick();
            in_valid_i  = 1'b0;
            out_ready_i = 1'b1;
            tick();
            out_ready_i = 1'b0;
        end

        // Fill to 7: full, held packet refused, then one pop of 2 reopens
        in_valid_i = 1'b1;
        in_mask_i  = 2'b11;
        repeat (3) begin
            set_pair();
            tick();
        end
        in_mask_i = 2'b01;
        set_pair();
        tick();
        check("full_count", 32'(count_o), 32'd7);
        check("full_ready", 32'(in_ready_o), 32'd0);
        in_mask_i = 2'b11;
        set_pair();
        repeat (2) tick();
        check("held_count", 32'(count_o), 32'd7);
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        check("after_pop_count", 32'(count_o), 32'd5);
        check("after_pop_ready", 32'(in_ready_o), 32'd1);
        repeat (3) tick();
        out_ready_i = 1'b0;

        // Steady stream of 2 in / 2 out across several pointer wraps
        in_valid_i = 1'b1;
        set_pair();
        tick();
        out_ready_i = 1'b1;
        for (int c = 0; c < 20; c++) begin
            set_pair();
            tick();
            check("stream_count", 32'(count_o), 32'd2);
        end
        in_valid_i = 1'b0;
        tick();
        out_ready_i = 1'b0;

        // Flush with push and pop both requested
        in_valid_i = 1'b1;
        repeat (3) begin
            set_pair();
            tick();
        end
        check("preflush_count", 32'(count_o), 32'd6);
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        set_pair();
        tick();
        check("flush_count", 32'(count_o), 32'd0);
        check("flush_valid", 32'(out_valid_o), 32'd0);
        flush_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        tick();
        in_valid_i = 1'b1;
        set_pair();
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // Reset in the middle of traffic
        in_valid_i = 1'b1;
        repeat (2) begin
            set_pair();
            tick();
        end
        rst_n = 1'b0;
        set_pair();
        tick();
        rst_n = 1'b1;
        check("midrst_count", 32'(count_o), 32'd0);
        check("midrst_ready", 32'(in_ready_o), 32'd1);
        set_pair();
        tick();
        in_valid_i = 1'b0;
        tick();

        // Random soak including empty masks, back-pressure and flushes
        for (int c = 0; c < 300; c++) begin
            in_valid_i  = ($urandom_range(0, 3) != 0);
            in_mask_i   = 2'($urandom_range(0, 3));
            out_ready_i = ($urandom_range(0, 2) == 0);
            flush_i     = ($urandom_range(0, 39) == 0);
            set_pair();
            tick();
        end
        flush_i    = 1'b0;
        in_valid_i = 1'b0;
        out_ready_i = 1'b1;
        repeat (5) tick();
        check("final_count", 32'(count_o), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
